// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold-off, sequential fetch, branch/jump redirect,
// exception entry/return via EPC, and halt/resume for the single-cycle core.
module pc_sequencer #(
    parameter int                  DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int                  BOOT_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic                  exc_req,
    input  logic                  eret,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic [DATA_WIDTH-1:0] epc,
    output logic [1:0]            exc_cause,
    output logic                  in_exc,
    output logic                  halted
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_EXTERNAL = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_boot_cnt;
    logic [DATA_WIDTH-1:0] r_epc;
    logic [1:0]            r_exc_cause;
    logic                  r_in_exc;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_redirect;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic                  w_exc_entry;
    logic [1:0]            w_entry_cause;
    logic                  w_eret_do;
    logic                  w_to_halt;
    logic                  w_to_run;

    assign w_pc_plus4   = pc_in + DATA_WIDTH'(4);
    assign w_target     = jump ? jump_target : branch_target;
    assign w_redirect   = jump | branch_taken;
    assign w_misaligned = (w_target[1:0] != 2'b00);

    always_comb begin
        w_pc_next     = RESET_VECTOR;
        w_exc_entry   = 1'b0;
        w_entry_cause = CAUSE_NONE;
        w_eret_do     = 1'b0;
        w_to_halt     = 1'b0;
        w_to_run      = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_pc_next = RESET_VECTOR;
            end
            S_RUN: begin
                if (exc_req && !r_in_exc) begin
                    w_pc_next     = EXC_VECTOR;
                    w_exc_entry   = 1'b1;
                    w_entry_cause = CAUSE_EXTERNAL;
                end else if (eret && r_in_exc) begin
                    w_pc_next = r_epc;
                    w_eret_do = 1'b1;
                end else if (halt_req) begin
                    w_pc_next = pc_in;
                    w_to_halt = 1'b1;
                end else if (stall) begin
                    w_pc_next = pc_in;
                end else if (w_redirect) begin
                    // A misaligned target inside the handler is dropped rather than nested.
                    if (!w_misaligned) begin
                        w_pc_next = w_target;
                    end else if (!r_in_exc) begin
                        w_pc_next     = EXC_VECTOR;
                        w_exc_entry   = 1'b1;
                        w_entry_cause = CAUSE_MISALIGN;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end else begin
                    w_pc_next = w_pc_plus4;
                end
            end
            S_HALT: begin
                if (exc_req && !r_in_exc) begin
                    w_pc_next     = EXC_VECTOR;
                    w_exc_entry   = 1'b1;
                    w_entry_cause = CAUSE_EXTERNAL;
                    w_to_run      = 1'b1;
                end else if (resume) begin
                    w_pc_next = w_pc_plus4;
                    w_to_run  = 1'b1;
                end else begin
                    w_pc_next = pc_in;
                end
            end
            default: begin
                w_pc_next = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_BOOT;
            r_boot_cnt  <= CNT_W'(BOOT_CYCLES - 1);
            r_epc       <= '0;
            r_exc_cause <= CAUSE_NONE;
            r_in_exc    <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_to_halt) begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (w_to_run) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase

            if (w_exc_entry) begin
                r_epc       <= pc_in;
                r_exc_cause <= w_entry_cause;
                r_in_exc    <= 1'b1;
            end else if (w_eret_do) begin
                r_exc_cause <= CAUSE_NONE;
                r_in_exc    <= 1'b0;
            end
        end
    end

    assign pc_next   = w_pc_next;
    assign epc       = r_epc;
    assign exc_cause = r_exc_cause;
    assign in_exc    = r_in_exc;
    assign halted    = (r_state == S_HALT);

endmodule
